// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the EX stage.
// Optional MADD (md_op 111) is enabled by defining MDU_MADD_EN.
module md_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b111;
`endif

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [63:0] res, res_nx;
    logic        wr_en, wr_en_nx;
    logic [31:0] hi, hi_nx;
    logic [31:0] lo, lo_nx;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divide on magnitudes, then restore signs: this keeps 0x8000_0000 / -1
    // well defined (quotient wraps to 0x8000_0000) without a special case.
    logic        div_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, d_safe;
    logic [31:0] q_mag, r_mag;
    logic [31:0] div_quo, div_rem;

    assign div_signed = (md_op == OP_DIV);
    assign a_neg      = div_signed & A[31];
    assign b_neg      = div_signed & B[31];
    assign a_mag      = a_neg ? (32'd0 - A) : A;
    assign b_mag      = b_neg ? (32'd0 - B) : B;
    assign d_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag      = a_mag / d_safe;
    assign r_mag      = a_mag % d_safe;
    assign div_quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign div_rem    = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case statements can leave one unassigned and infer a latch.
        state_nx = state;
        cnt_nx   = cnt;
        res_nx   = res;
        wr_en_nx = wr_en;
        hi_nx    = hi;
        lo_nx    = lo;

        case (state)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT: begin
                            res_nx   = prod_s;
                            cnt_nx   = MUL_LOAD;
                            wr_en_nx = 1'b1;
                            state_nx = RUN;
                        end
                        OP_MULTU: begin
                            res_nx   = prod_u;
                            cnt_nx   = MUL_LOAD;
                            wr_en_nx = 1'b1;
                            state_nx = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            res_nx   = {div_rem, div_quo};
                            cnt_nx   = DIV_LOAD;
                            wr_en_nx = (B != 32'd0);
                            state_nx = RUN;
                        end
                        OP_MTHI: hi_nx = A;
                        OP_MTLO: lo_nx = A;
`ifdef MDU_MADD_EN
                        OP_MADD: begin
                            res_nx   = {hi, lo} + prod_s;
                            cnt_nx   = MUL_LOAD;
                            wr_en_nx = 1'b1;
                            state_nx = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // start is deliberately not looked at here; hazard logic stalls instead.
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx = IDLE;
                    if (wr_en) begin
                        {hi_nx, lo_nx} = res;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            res   <= 64'd0;
            wr_en <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            res   <= res_nx;
            wr_en <= wr_en_nx;
            hi    <= hi_nx;
            lo    <= lo_nx;
        end
    end

    assign busy = (state == RUN);
    assign HI   = hi;
    assign LO   = lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized ops
// compared against an arithmetic reference model of HI/LO and latency.
module tb_md_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: updates m_hi/m_lo and returns expected busy cycles.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, output int lat);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, pu;
        logic [63:0]     acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        lat = 0;
        case (op)
            3'd1: begin acc = 64'(sa * sb); {m_hi, m_lo} = acc; lat = MUL_N; end
            3'd2: begin pu = ua * ub; {m_hi, m_lo} = pu; lat = MUL_N; end
            3'd3: begin
                lat = DIV_N;
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            3'd4: begin
                lat = DIV_N;
                if (b != 0) begin
                    pu = ua / ub;
                    m_lo = pu[31:0];
                    pu = ua % ub;
                    m_hi = pu[31:0];
                end
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            3'd7: begin
`ifdef MDU_MADD_EN
                acc = {m_hi, m_lo} + 64'(sa * sb);
                {m_hi, m_lo} = acc;
                lat = MUL_N;
`endif
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int exp_n, n;
        model_op(op, a, b, exp_n);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== exp_n) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d expected %0d", name, n, exp_n);
        end
        checks++;
        if (HI !== m_hi) begin
            errors++;
            $display("FAIL %s HI got %h expected %h", name, HI, m_hi);
        end
        checks++;
        if (LO !== m_lo) begin
            errors++;
            $display("FAIL %s LO got %h expected %h", name, LO, m_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        A = 32'd0;
        B = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset busy/HI/LO got %b/%h/%h expected 0/0/0", busy, HI, LO);
        end
    endtask

    task automatic test_mult();
        run_op("mult_neg2x3", 3'd1, 32'hFFFF_FFFE, 32'd3);
        run_op("multu_ffx2", 3'd2, 32'hFFFF_FFFF, 32'd2);
        run_op("mult_ffx2",  3'd1, 32'hFFFF_FFFF, 32'd2);
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mult_ffx2_const got %h_%h expected ffffffff_fffffffe", HI, LO);
        end
    endtask

    task automatic test_div();
        run_op("div_neg7by2", 3'd3, 32'hFFFF_FFF9, 32'd2);
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_neg7by2_const got %h_%h expected ffffffff_fffffffd", HI, LO);
        end
        run_op("divu_7by2", 3'd4, 32'd7, 32'd2);
        run_op("mthi", 3'd5, 32'h0000_1234, 32'd0);
        run_op("mtlo", 3'd6, 32'h0000_5678, 32'd0);
        run_op("div_by_zero", 3'd3, 32'd9, 32'd0);
        checks++;
        if (HI !== 32'h0000_1234 || LO !== 32'h0000_5678) begin
            errors++;
            $display("FAIL div_by_zero_keep got %h_%h expected 00001234_00005678", HI, LO);
        end
        run_op("divu_by_zero", 3'd4, 32'hFFFF_0000, 32'd0);
        run_op("div_overflow", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_overflow_const got %h_%h expected 00000000_80000000", HI, LO);
        end
    endtask

    task automatic test_nop();
        run_op("op_none", 3'd0, 32'hAAAA_AAAA, 32'h5555_5555);
    endtask

    task automatic test_start_while_busy();
        int n;
        start = 1'b1;
        md_op = 3'd1;
        A = 32'd3;
        B = 32'd4;
        tick();
        md_op = 3'd0;
        start = 1'b0;
        tick();
        start = 1'b1;
        md_op = 3'd6;
        A = 32'h0000_DEAD;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        n = 2;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        m_hi = 32'd0;
        m_lo = 32'd12;
        checks++;
        if (n !== MUL_N) begin
            errors++;
            $display("FAIL busy_ignore cycles got %0d expected %0d", n, MUL_N);
        end
        checks++;
        if (HI !== 32'd0 || LO !== 32'd12) begin
            errors++;
            $display("FAIL busy_ignore result got %h_%h expected 00000000_0000000c", HI, LO);
        end
    endtask

    task automatic test_reset_mid_op();
        bit bad;
        start = 1'b1;
        md_op = 3'd1;
        A = 32'd7;
        B = 32'd9;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid busy/HI/LO got %b/%h/%h expected 0/0/0", busy, HI, LO);
        end
        bad = 1'b0;
        for (int i = 0; i < MUL_N + 3; i++) begin
            tick();
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_mid_no_commit got busy/HI/LO %b/%h/%h expected 0/0/0", busy, HI, LO);
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_mult",  3'd1, 32'h0001_0000, 32'h0001_0000);
        run_op("b2b_div",   3'd3, 32'd100, 32'hFFFF_FFF9);
        run_op("b2b_multu", 3'd2, 32'h8000_0001, 32'h8000_0001);
        run_op("b2b_mthi",  3'd5, 32'hCAFE_F00D, 32'd0);
        run_op("b2b_divu",  3'd4, 32'hFFFF_FFFF, 32'd16);
    endtask

    task automatic test_madd();
        run_op("madd_hi0",  3'd5, 32'd0, 32'd0);
        run_op("madd_lo10", 3'd6, 32'd10, 32'd0);
        run_op("madd_5x6",  3'd7, 32'd5, 32'd6);
`ifdef MDU_MADD_EN
        checks++;
        if (LO !== 32'd40 || HI !== 32'd0) begin
            errors++;
            $display("FAIL madd_const got %h_%h expected 00000000_00000028", HI, LO);
        end
`else
        checks++;
        if (LO !== 32'd10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL madd_disabled got LO %h busy %b expected 0000000a 0", LO, busy);
        end
`endif
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(7, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(7, 0))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(9, 1));
                3: a = -32'($urandom_range(100, 1));
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_nop();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        test_madd();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
